aes_uart_tx_serializer: RTL
===========================

AES_UART_TX_SERIALIZER -- requirements
Module: aes_uart_tx_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, the clk cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of 128-bit blocks buffered (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock: rising edge, all logic.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sys_en, input, 1, global enable: low freezes serializer and baud counter.
REQ-006 SHALL have port blk_valid, input, 1, a one-cycle strobe marking a 128-bit block (driven from enc_out_valid).
REQ-007 SHALL have port blk_data, input, 128, the block payload (driven from cipher_text_out).
REQ-008 SHALL have port tx, output, 1, the UART 8N1 serial line, idle high.
REQ-009 SHALL have port busy, output, 1, high while a frame is in flight or the FIFO is non-empty.
REQ-010 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, the number of blocks currently stored.
REQ-011 SHALL have port overflow, output, 1, sticky flag: a block was dropped.

Function
REQ-012 SHALL push blk_data into the FIFO on any edge with blk_valid=1 and FIFO not full; push is independent of sys_en.
REQ-013 SHALL accept a push on a full FIFO when a pop occurs in the same cycle; count is unchanged.
REQ-014 SHALL drop the block on blk_valid with FIFO full and no same-cycle pop, setting overflow=1 until reset; FIFO contents are unaltered.
REQ-015 SHALL use FSM states IDLE, LOAD, START, DATA and STOP.
REQ-016 SHALL move IDLE->LOAD when the FIFO is non-empty and sys_en=1.
REQ-017 SHALL, in LOAD (1 cycle), pop the head into a 128-bit shift register, clear the byte index to 0, then go to START.
REQ-018 SHALL send START (tx=0), DATA (8 bits), then STOP (tx=1), each bit lasting CLKS_PER_BIT enabled cycles.
REQ-019 SHALL send bytes MSB-byte first (blk_data[127:120] first) and bits LSB-first within each byte.
REQ-020 SHALL, after STOP, go to START for the next byte if the byte index is <15, with no idle gap.
REQ-021 SHALL, after STOP with byte index 15, go to LOAD if the FIFO is non-empty, otherwise to IDLE.
REQ-022 SHALL have a latency of exactly 2 clk edges from a blk_valid edge (FIFO empty, IDLE, sys_en=1) to tx falling.
REQ-023 SHALL take exactly 160*CLKS_PER_BIT + 1 cycles to transmit one block, including LOAD.
REQ-024 SHALL, with sys_en=0, hold all FSM, baud-counter, shift and index registers, keeping tx at its current level; resume is seamless.
REQ-025 SHALL use a baud counter that counts 0..CLKS_PER_BIT-1 and wraps; the bit advances on the wrap.
REQ-026 SHALL use FIFO pointers that wrap modulo FIFO_DEPTH; fifo_count reaches FIFO_DEPTH when full and 0 when empty.
REQ-027 SHALL drive busy = (state!=IDLE) | (fifo_count!=0).

Reset
REQ-028 SHALL, on rst (any time, mid-frame included), immediately set tx=1, state=IDLE, fifo_count=0, overflow=0 and busy=0, and clear the baud counter and byte index.
REQ-029 SHALL NOT reset the FIFO storage array or the shift-register data.
REQ-030 SHALL ignore a blk_valid in the first edge after rst deasserts only if rst is still high at that edge.

Structure
REQ-031 SHALL define UART_BITS=8, AES_BLOCK_BYTES=16 and the FSM state encoding in the shared aes_uart_pkg package.
REQ-032 SHALL implement the FIFO as one sub-module, blk_fifo (parameters WIDTH=128, DEPTH), with push, pop, full, empty and count.
REQ-033 SHALL keep the FSM, baud counter and shift register in the top module.

Verification (CLKS_PER_BIT=4)
REQ-034 SHALL verify a single block: blk_data=69c4e0d86a7b0430d8cdb78070b4c55a -> tx falls 2 cycles later; decoded bytes are 69,c4,...,5a; the first byte's bits read 1,0,0,1,0,1,1,0; busy falls after 641 cycles.
REQ-035 SHALL verify a back-to-back burst: 4 consecutive blk_valid cycles -> fifo_count peaks at 3; 64 bytes arrive in order with no gap between blocks; overflow=0.
REQ-036 SHALL verify overflow: 6 consecutive blk_valid with FIFO_DEPTH=4 -> 5 blocks sent (1 popped, 4 stored); overflow=1; the 6th block never appears.
REQ-037 SHALL verify freeze: sys_en=0 for 10 cycles mid-DATA -> tx is constant throughout; the decoded stream is identical to the unfrozen run, lengthened by 10 cycles.
REQ-038 SHALL verify reset mid-frame: rst pulse during byte 5 -> tx=1 and fifo_count=0 the same cycle; a block sent afterward transmits correctly from byte 0.
REQ-039 SHALL verify a simultaneous push and pop at full: blk_valid during LOAD with count=4 -> the block is accepted, count stays 4, and overflow=0.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared constants and FSM encoding for the AES block to UART byte serializer.
package aes_uart_pkg;

    localparam int unsigned UART_BITS       = 8;
    localparam int unsigned AES_BLOCK_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } tx_state_e;

endpackage

// File: rtl/aes_uart_tx_serializer_blk_fifo.sv
// Power-of-two block FIFO; a push on a full FIFO is taken only alongside a pop.
module blk_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             wr_en, rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_MAX);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/aes_uart_tx_serializer.sv
// Buffers 128-bit AES blocks and streams them MSB byte first as UART 8N1 frames.
module aes_uart_tx_serializer
    import aes_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sys_en,
    input  logic                          blk_valid,
    input  logic [127:0]                  blk_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int unsigned BLK_W  = UART_BITS * AES_BLOCK_BYTES;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [2:0]        BIT_LAST  = 3'(UART_BITS - 1);
    localparam logic [3:0]        BYTE_LAST = 4'(AES_BLOCK_BYTES - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [3:0]        byte_q, byte_d;
    logic [BLK_W-1:0]  shift_q, shift_d;
    logic              overflow_q;

    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [BLK_W-1:0]  fifo_rdata;
    logic              baud_wrap;

    blk_fifo #(
        .WIDTH (BLK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (blk_valid),
        .pop   (pop),
        .wdata (blk_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        pop     = 1'b0;
        if (sys_en) begin
            unique case (state_q)
                IDLE: if (!fifo_empty) state_d = LOAD;
                LOAD: begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    byte_d  = '0;
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = START;
                end
                START: begin
                    baud_d = baud_wrap ? '0 : baud_q + BAUD_ONE;
                    if (baud_wrap) begin
                        bit_d   = '0;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    baud_d = baud_wrap ? '0 : baud_q + BAUD_ONE;
                    if (baud_wrap) begin
                        if (bit_q == BIT_LAST) state_d = STOP;
                        else                   bit_d   = bit_q + 3'd1;
                    end
                end
                STOP: begin
                    baud_d = baud_wrap ? '0 : baud_q + BAUD_ONE;
                    if (baud_wrap) begin
                        if (byte_q != BYTE_LAST) begin
                            byte_d  = byte_q + 4'd1;
                            shift_d = shift_q << UART_BITS;
                            state_d = START;
                        end else if (!fifo_empty) begin
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            if (blk_valid && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    // Payload register is not reset; it is always reloaded in LOAD before use.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    // The byte on the wire is always the top byte of the shift register.
    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[{4'hf, bit_q}];
            default: tx = 1'b1;
        endcase
    end

    assign busy     = (state_q != IDLE) || (fifo_count != '0);
    assign overflow = overflow_q;

endmodule
